// File: rtl/alu_dispatch_pkg.sv
// rtl/alu_dispatch_pkg.sv - shared types, sizes and one-hot encoder for the ALU dispatch slice
package alu_dispatch_pkg;

    localparam int IQ_ENTRIES = 8;
    localparam int IDXW       = $clog2(IQ_ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic            valid;  // exactly one bit set
        logic            multi;  // two or more bits set
        logic [IDXW-1:0] idx;    // index of the set bit (meaningful only when valid)
    } onehot_enc_t;

    // Population-count based encoder: idx is the OR of set-bit indices, which
    // equals the true index whenever the vector is one-hot.
    function automatic onehot_enc_t onehot_encode(input logic [IQ_ENTRIES-1:0] vec);
        onehot_enc_t r;
        int unsigned n;
        r = '0;
        n = 0;
        for (int i = 0; i < IQ_ENTRIES; i++) begin
            if (vec[i]) begin
                n++;
                r.idx = r.idx | IDXW'(i);
            end
        end
        r.valid = (n == 1);
        r.multi = (n > 1);
        return r;
    endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - issue/writeback bundle between selector, dispatch and writeback
interface alu_dispatch_if;
    import alu_dispatch_pkg::*;

    logic                  ce;
    logic [IQ_ENTRIES-1:0] issue0;
    logic [IQ_ENTRIES-1:0] issue1;
    logic [IQ_ENTRIES-1:0] iq_mc;
    logic [IQ_ENTRIES-1:0] flush_mask;
    logic                  alu0_idle;
    logic                  alu1_idle;
    logic                  alu0_go;
    logic                  alu1_go;
    logic [IDXW-1:0]       alu0_id;
    logic [IDXW-1:0]       alu1_id;
    logic                  alu0_wb_valid;
    logic                  alu1_wb_valid;
    logic                  alu0_wb_ack;
    logic                  alu1_wb_ack;
    logic                  issue_err;

    modport master (
        output ce, issue0, issue1, iq_mc, flush_mask, alu0_wb_ack, alu1_wb_ack,
        input  alu0_idle, alu1_idle, alu0_go, alu1_go, alu0_id, alu1_id,
               alu0_wb_valid, alu1_wb_valid, issue_err
    );

    modport slave (
        input  ce, issue0, issue1, iq_mc, flush_mask, alu0_wb_ack, alu1_wb_ack,
        output alu0_idle, alu1_idle, alu0_go, alu1_go, alu0_id, alu1_id,
               alu0_wb_valid, alu1_wb_valid, issue_err
    );

endinterface

// File: rtl/alu_dispatch_slot_fsm.sv
// rtl/alu_dispatch_slot_fsm.sv - one ALU execution slot: accept, execute countdown, writeback handshake
module alu_slot_fsm
    import alu_dispatch_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  i_issue_any,
    input  logic                  i_issue_vld,
    input  logic [IDXW-1:0]       i_issue_idx,
    input  logic                  i_issue_mc,
    input  logic                  i_issue_flushed,
    input  logic [IQ_ENTRIES-1:0] i_flush_mask,
    input  logic                  i_wb_ack,
    output logic                  o_idle,
    output logic                  o_go,
    output logic [IDXW-1:0]       o_id,
    output logic                  o_wb_valid
);

    localparam logic [3:0] MC_CNT = 4'(MC_LAT - 1);

    slot_state_e     r_state;
    slot_state_e     w_next;
    logic [3:0]      r_cnt;
    logic [IDXW-1:0] r_id;
    logic            r_go;
    logic            w_accept;
    logic            w_flush_hit;

    // An issue is taken only when the slot is free, the vector is one-hot and
    // the entry is not being squashed in the same cycle.
    assign w_accept    = ce & (r_state == S_IDLE) & i_issue_vld & ~i_issue_flushed;
    assign w_flush_hit = (r_state != S_IDLE) & i_flush_mask[r_id];

    // State register; frozen while ce is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a flush of the held entry beats both EXEC->WB and ack.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_flush_hit)        w_next = S_IDLE;
                else if (r_cnt == 4'd0) w_next = S_WB;
            end
            S_WB: begin
                if (w_flush_hit || i_wb_ack) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Counter, held id and go pulse; go is re-evaluated only on enabled edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
            r_id  <= '0;
            r_go  <= 1'b0;
        end else if (ce) begin
            r_go <= w_accept;
            if (w_accept) begin
                r_id  <= i_issue_idx;
                r_cnt <= i_issue_mc ? MC_CNT : 4'd0;
            end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Outputs; wb_valid is masked in the cycle its entry is being flushed.
    always_comb begin
        o_idle     = (r_state == S_IDLE) & ~i_issue_any;
        o_wb_valid = (r_state == S_WB) & ~i_flush_mask[r_id];
        o_go       = r_go;
        o_id       = r_id;
    end

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - encodes issue vectors and runs one execution slot per ALU
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int NUM_ALU = 2,
    parameter int MC_LAT  = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_dispatch_if.slave bus
);

    onehot_enc_t w_enc0;
    onehot_enc_t w_enc1;
    logic        w_multi1;
    logic        r_issue_err;

    assign w_enc0 = onehot_encode(bus.issue0);
    assign w_enc1 = onehot_encode(bus.issue1);

    alu_slot_fsm #(.MC_LAT(MC_LAT)) u_slot0 (
        .clk             (clk),
        .rst             (rst),
        .ce              (bus.ce),
        .i_issue_any     (|bus.issue0),
        .i_issue_vld     (w_enc0.valid),
        .i_issue_idx     (w_enc0.idx),
        .i_issue_mc      (bus.iq_mc[w_enc0.idx]),
        .i_issue_flushed (bus.flush_mask[w_enc0.idx]),
        .i_flush_mask    (bus.flush_mask),
        .i_wb_ack        (bus.alu0_wb_ack),
        .o_idle          (bus.alu0_idle),
        .o_go            (bus.alu0_go),
        .o_id            (bus.alu0_id),
        .o_wb_valid      (bus.alu0_wb_valid)
    );

    generate
        if (NUM_ALU >= 2) begin : g_slot1
            assign w_multi1 = w_enc1.multi;

            alu_slot_fsm #(.MC_LAT(MC_LAT)) u_slot1 (
                .clk             (clk),
                .rst             (rst),
                .ce              (bus.ce),
                .i_issue_any     (|bus.issue1),
                .i_issue_vld     (w_enc1.valid),
                .i_issue_idx     (w_enc1.idx),
                .i_issue_mc      (bus.iq_mc[w_enc1.idx]),
                .i_issue_flushed (bus.flush_mask[w_enc1.idx]),
                .i_flush_mask    (bus.flush_mask),
                .i_wb_ack        (bus.alu1_wb_ack),
                .o_idle          (bus.alu1_idle),
                .o_go            (bus.alu1_go),
                .o_id            (bus.alu1_id),
                .o_wb_valid      (bus.alu1_wb_valid)
            );
        end else begin : g_no_slot1
            // Single-ALU build: slot 1 never advertises itself and issue1 is ignored.
            assign w_multi1          = 1'b0;
            assign bus.alu1_idle     = 1'b0;
            assign bus.alu1_go       = 1'b0;
            assign bus.alu1_id       = '0;
            assign bus.alu1_wb_valid = 1'b0;
        end
    endgenerate

    // Sticky error flag for any multi-hot issue vector seen on an enabled edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_err <= 1'b0;
        end else if (bus.ce && (w_enc0.multi || w_multi1)) begin
            r_issue_err <= 1'b1;
        end
    end

    assign bus.issue_err = r_issue_err;

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - directed self-checking bench for alu_dispatch
module tb_alu_dispatch;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    alu_dispatch_if bus ();
    alu_dispatch_if bus1 ();

    alu_dispatch #(.NUM_ALU(2), .MC_LAT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_dispatch #(.NUM_ALU(1), .MC_LAT(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.ce = 1'b1;           bus1.ce = 1'b1;
        bus.issue0 = '0;         bus1.issue0 = '0;
        bus.issue1 = '0;         bus1.issue1 = '0;
        bus.iq_mc = '0;          bus1.iq_mc = '0;
        bus.flush_mask = '0;     bus1.flush_mask = '0;
        bus.alu0_wb_ack = 1'b0;  bus1.alu0_wb_ack = 1'b0;
        bus.alu1_wb_ack = 1'b0;  bus1.alu1_wb_ack = 1'b0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("rst_idle0", bus.alu0_idle, 1);
        check("rst_idle1", bus.alu1_idle, 1);
        check("rst_go0", bus.alu0_go, 0);
        check("rst_wbv0", bus.alu0_wb_valid, 0);
        check("rst_wbv1", bus.alu1_wb_valid, 0);
        check("rst_id0", bus.alu0_id, 0);
        check("rst_err", bus.issue_err, 0);
        tick();
        tick();
        rst = 1'b1;

        // Single-cycle op on ALU0: issue 0x10 -> id 4
        bus.issue0 = 8'h10;
        #1;
        check("sc_idle_issue_cycle", bus.alu0_idle, 0);
        tick();
        bus.issue0 = '0;
        #1;
        check("sc_go", bus.alu0_go, 1);
        check("sc_id", bus.alu0_id, 4);
        check("sc_wbv_early", bus.alu0_wb_valid, 0);
        check("sc_idle_exec", bus.alu0_idle, 0);
        tick();
        check("sc_go_pulse_end", bus.alu0_go, 0);
        check("sc_wbv", bus.alu0_wb_valid, 1);
        check("sc_wb_id", bus.alu0_id, 4);
        bus.alu0_wb_ack = 1'b1;
        tick();
        bus.alu0_wb_ack = 1'b0;
        #1;
        check("sc_idle_after_ack", bus.alu0_idle, 1);
        check("sc_wbv_after_ack", bus.alu0_wb_valid, 0);

        // Multi-cycle op on ALU1: issue 0x80 -> id 7, WB after 4 execute edges
        bus.issue1 = 8'h80;
        bus.iq_mc  = 8'h80;
        tick();
        bus.issue1 = '0;
        #1;
        check("mc_go", bus.alu1_go, 1);
        check("mc_id", bus.alu1_id, 7);
        tick();
        tick();
        tick();
        check("mc_wbv_early", bus.alu1_wb_valid, 0);
        tick();
        check("mc_wbv", bus.alu1_wb_valid, 1);
        check("mc_wb_id", bus.alu1_id, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mc_hold_wbv", bus.alu1_wb_valid, 1);
            check("mc_hold_id", bus.alu1_id, 7);
        end
        bus.alu1_wb_ack = 1'b1;
        tick();
        bus.alu1_wb_ack = 1'b0;
        bus.iq_mc = '0;
        #1;
        check("mc_idle_after_ack", bus.alu1_idle, 1);

        // Flush during EXEC: entry 3, multi-cycle so it is still executing
        bus.issue0 = 8'h08;
        bus.iq_mc  = 8'h08;
        tick();
        bus.issue0 = '0;
        #1;
        check("fl_id", bus.alu0_id, 3);
        tick();
        bus.flush_mask = 8'h08;
        tick();
        bus.flush_mask = '0;
        bus.iq_mc = '0;
        #1;
        check("fl_idle", bus.alu0_idle, 1);
        check("fl_wbv", bus.alu0_wb_valid, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("fl_wbv_never", bus.alu0_wb_valid, 0);
        end

        // Issue and flush of the same entry in one cycle: no accept
        bus.issue0     = 8'h02;
        bus.flush_mask = 8'h02;
        tick();
        bus.issue0     = '0;
        bus.flush_mask = '0;
        #1;
        check("aflush_go", bus.alu0_go, 0);
        check("aflush_idle", bus.alu0_idle, 1);
        tick();
        check("aflush_wbv", bus.alu0_wb_valid, 0);

        // Multi-hot issue: no accept, sticky error
        bus.issue0 = 8'h05;
        #1;
        check("mh_idle_comb", bus.alu0_idle, 0);
        tick();
        bus.issue0 = '0;
        #1;
        check("mh_go", bus.alu0_go, 0);
        check("mh_idle", bus.alu0_idle, 1);
        check("mh_err", bus.issue_err, 1);
        repeat (10) tick();
        check("mh_err_sticky", bus.issue_err, 1);

        // ce low for 3 cycles right after a multi-cycle accept: WB 3 cycles late
        bus.issue0 = 8'h01;
        bus.iq_mc  = 8'h01;
        tick();
        bus.issue0 = '0;
        bus.ce     = 1'b0;
        #1;
        check("ce_go_first", bus.alu0_go, 1);
        tick();
        tick();
        tick();
        check("ce_go_held", bus.alu0_go, 1);
        check("ce_wbv_frozen", bus.alu0_wb_valid, 0);
        bus.ce = 1'b1;
        tick();
        check("ce_go_drop", bus.alu0_go, 0);
        tick();
        tick();
        check("ce_wbv_early", bus.alu0_wb_valid, 0);
        tick();
        check("ce_wbv_late", bus.alu0_wb_valid, 1);
        bus.alu0_wb_ack = 1'b1;
        tick();
        bus.alu0_wb_ack = 1'b0;
        bus.iq_mc = '0;
        #1;
        check("ce_idle", bus.alu0_idle, 1);

        // Single-ALU build: issue1 ignored entirely
        bus1.issue1 = 8'h01;
        #1;
        check("n1_idle1", bus1.alu1_idle, 0);
        tick();
        check("n1_go1", bus1.alu1_go, 0);
        check("n1_idle0", bus1.alu0_idle, 1);
        bus1.issue1 = 8'h03;
        tick();
        tick();
        check("n1_wbv1", bus1.alu1_wb_valid, 0);
        check("n1_err", bus1.issue_err, 0);
        bus1.issue1 = '0;

        // Asynchronous reset two cycles into a multi-cycle EXEC
        bus.issue0 = 8'h04;
        bus.iq_mc  = 8'h04;
        tick();
        bus.issue0 = '0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("arst_wbv", bus.alu0_wb_valid, 0);
        check("arst_idle", bus.alu0_idle, 1);
        check("arst_id", bus.alu0_id, 0);
        check("arst_err", bus.issue_err, 0);
        check("arst_go", bus.alu0_go, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
